// File: rtl/bus_pkg.sv
// Shared constants and types for the serial-bus arbiter: packet layout,
// FSM state encoding, debug view, and a sizing helper.
package bus_pkg;

    localparam int PACKET_BITS = 79;

    // Bit positions inside a captured packet (first received bit lands at MSB).
    localparam int DATA_MSB = 67;
    localparam int DATA_LSB = 4;
    localparam int SRC_MSB  = 77;
    localparam int SRC_LSB  = 74;
    localparam int DST_MSB  = 73;
    localparam int DST_LSB  = 70;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_RECV      = 3'd4,
        ST_RESULT    = 3'd5
    } state_e;

    typedef struct packed {
        state_e                 state;
        logic [PACKET_BITS-1:0] capture;
    } dbg_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: one-hot pick of the first set request at or above
// ptr_i, wrapping to the lowest set request when nothing lies above it.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic          valid_o
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] src;

    always_comb begin
        hi_mask = ~((N'(1) << ptr_i) - N'(1));
        hi_req  = req_i & hi_mask;
        src     = (hi_req != '0) ? hi_req : req_i;
        // Isolate lowest set bit of the chosen half.
        pick_o  = src & (~src + N'(1));
        valid_o = |req_i;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter for a shared serial line: grants one node at a time, tracks its
// 79-bit packet, captures the response and retries on NACK or timeout.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_NODES     = 4,
    parameter int START_TIMEOUT = 16,
    parameter int RESP_TIMEOUT  = 160,
    parameter int MAX_RETRY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_NODES-1:0] req,
    input  logic                 line_in,
    output logic [NUM_NODES-1:0] grant,
    output logic [NUM_NODES-1:0] done,
    output logic [NUM_NODES-1:0] fail,
    output logic                 busy,
    output dbg_t                 dbg
);

    // Handshake: a node raises req and holds it until it sees its done or
    // fail pulse; dropping it before its start bit withdraws the request.

    localparam int IW      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int CNT_MAX = max3(PACKET_BITS, START_TIMEOUT, RESP_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int AW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] LAST_BIT   = CW'(PACKET_BITS - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] RESP_LAST  = CW'(RESP_TIMEOUT - 1);
    localparam logic [AW-1:0] RETRY_LIM  = AW'(MAX_RETRY);
    localparam logic [IW-1:0] LAST_NODE  = IW'(NUM_NODES - 1);

    state_e                 state_q, state_d;
    logic [NUM_NODES-1:0]   grant_q, grant_d;
    logic [NUM_NODES-1:0]   done_q, done_d;
    logic [NUM_NODES-1:0]   fail_q, fail_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          attempt_q, attempt_d;
    logic [PACKET_BITS-1:0] cap_q, cap_d;

    logic [NUM_NODES-1:0]   pick;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic [PACKET_BITS-1:0] cap_shift;
    logic                   attempt_bad;

    rr_pick #(
        .N  (NUM_NODES),
        .IW (IW)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            fail_q    <= '0;
            ptr_q     <= '0;
            gidx_q    <= '0;
            cnt_q     <= '0;
            attempt_q <= '0;
            cap_q     <= '1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            cnt_q     <= cnt_d;
            attempt_q <= attempt_d;
            cap_q     <= cap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        fail_d      = '0;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;
        attempt_d   = attempt_q;
        cap_d       = cap_q;
        attempt_bad = 1'b0;
        cap_shift   = {cap_q[PACKET_BITS-2:0], line_in};

        pick_idx = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d   = ST_GRANT;
                    grant_d   = pick;
                    gidx_d    = pick_idx;
                    cnt_d     = '0;
                    attempt_d = '0;
                end
            end
            ST_GRANT: begin
                if ((req & grant_q) == '0) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    cnt_d     = '0;
                    attempt_d = '0;
                end else if (!line_in) begin
                    state_d = ST_SEND;
                    cnt_d   = CW'(1);
                end else if (cnt_q == START_LAST) begin
                    attempt_bad = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SEND: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_WAIT_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_RESP: begin
                if (!line_in) begin
                    state_d = ST_RECV;
                    cap_d   = cap_shift;
                    cnt_d   = CW'(1);
                end else if (cnt_q == RESP_LAST) begin
                    attempt_bad = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RECV: begin
                cap_d = cap_shift;
                if (cnt_q == LAST_BIT) begin
                    // Only an all-ones data field is an ACK.
                    if (&cap_shift[DATA_MSB:DATA_LSB]) begin
                        state_d = ST_RESULT;
                        grant_d = '0;
                        done_d  = grant_q;
                    end else begin
                        attempt_bad = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESULT: begin
                state_d   = ST_IDLE;
                ptr_d     = (gidx_q == LAST_NODE) ? '0 : gidx_q + IW'(1);
                attempt_d = '0;
                cnt_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (attempt_bad) begin
            cnt_d = '0;
            if (attempt_q < RETRY_LIM) begin
                attempt_d = attempt_q + AW'(1);
                state_d   = ST_GRANT;
            end else begin
                state_d = ST_RESULT;
                grant_d = '0;
                fail_d  = grant_q;
            end
        end
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        grant         = grant_q;
        done          = done_q;
        fail          = fail_q;
        dbg.state     = state_q;
        dbg.capture   = cap_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: drives packets and responses on the serial
// line, queues expected done/fail pulses and checks grant timing and retries.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N        = 4;
    localparam int START_TO = 16;
    localparam int RESP_TO  = 160;
    localparam logic [PACKET_BITS-1:0] ALL1 = '1;
    localparam logic [63:0] DATA_ONES = '1;
    localparam logic [63:0] DATA_ZERO = '0;
    localparam logic [63:0] DATA_MIX  = 64'hFFFF_FFFF_FFFF_FFFE;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         line_in;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic [N-1:0] fail;
    logic         busy;
    dbg_t         dbg;

    logic [N:0]   exp_q[$];
    logic [N:0]   mon_got;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           inv_err  = 0;

    bus_arbiter #(
        .NUM_NODES     (N),
        .START_TIMEOUT (START_TO),
        .RESP_TIMEOUT  (RESP_TO),
        .MAX_RETRY     (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .line_in (line_in),
        .grant   (grant),
        .done    (done),
        .fail    (fail),
        .busy    (busy),
        .dbg     (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops one expectation per done/fail pulse; tracks invariants.
    always @(posedge clk) begin
        #2;
        if (!$onehot0(grant)) inv_err++;
        if (done != '0 && fail != '0) inv_err++;
        if ((dbg.state == ST_IDLE || dbg.state == ST_RESULT) && grant != '0) inv_err++;
        if (done != '0 || fail != '0) begin
            mon_got = (fail != '0) ? {1'b1, fail} : {1'b0, done};
            if (exp_q.size() == 0) check("unexpected_pulse", mon_got, '0);
            else check("scoreboard", mon_got, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_packet();
        for (int i = 0; i < PACKET_BITS; i++) begin
            @(negedge clk);
            line_in = (i == 0) ? 1'b0 : 1'(i % 2);
        end
        @(negedge clk);
        line_in = 1'b1;
    endtask

    task automatic send_response(input int gap, input logic [63:0] data, input int nbits);
        repeat (gap) begin
            @(negedge clk);
            line_in = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == 0) line_in = 1'b0;
            else if (i >= 11 && i <= 74) line_in = data[74 - i];
            else line_in = 1'b1;
        end
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] exp_g, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (grant == '0 && lat < 20);
        check({name, "_grant"}, grant, exp_g);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic expect_eval(input string name, input logic [N-1:0] exp_done,
                               input logic [N-1:0] exp_fail, input logic [N-1:0] exp_grant);
        @(posedge clk);
        #1;
        check({name, "_done"}, done, exp_done);
        check({name, "_fail"}, fail, exp_fail);
        check({name, "_grant"}, grant, exp_grant);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst     = 1'b1;
        req     = '0;
        line_in = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("reset_grant", grant, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_pulses", {done, fail}, '0);
        check("reset_capture", dbg.capture, ALL1);
        @(negedge clk);
        rst = 1'b0;

        // Round robin from ptr 0, ACK on node 0.
        @(negedge clk);
        req = 4'b0101;
        wait_grant("rr_first", 4'b0001, 1);
        exp_q.push_back({1'b0, 4'b0001});
        send_packet();
        send_response(0, DATA_ONES, PACKET_BITS);
        expect_eval("ack0", 4'b0001, 4'b0000, 4'b0000);
        check("result_busy", busy, 1'b1);
        @(negedge clk);
        req = 4'b0100;
        wait_grant("rr_after_ack", 4'b0100, 2);

        // Three NACKs on node 2: two regrants, then fail.
        exp_q.push_back({1'b1, 4'b0100});
        send_packet();
        send_response(0, DATA_ZERO, PACKET_BITS);
        expect_eval("nack1", 4'b0000, 4'b0000, 4'b0100);
        send_packet();
        send_response(0, DATA_MIX, PACKET_BITS);
        expect_eval("nack2", 4'b0000, 4'b0000, 4'b0100);
        send_packet();
        send_response(0, DATA_ZERO, PACKET_BITS);
        expect_eval("nack3", 4'b0000, 4'b0100, 4'b0000);
        @(negedge clk);
        req = 4'b1011;
        wait_grant("rr_after_fail", 4'b1000, 2);

        // Node 3 never drives a start bit: fail after three 16-cycle windows.
        exp_q.push_back({1'b1, 4'b1000});
        repeat (3 * START_TO - 1) @(posedge clk);
        #1;
        check("start_to_early_fail", fail, 4'b0000);
        check("start_to_regrant", grant, 4'b1000);
        @(posedge clk);
        #1;
        check("start_to_fail", fail, 4'b1000);
        check("start_to_grant", grant, 4'b0000);
        @(negedge clk);
        req = 4'b0011;
        wait_grant("rr_after_start_to", 4'b0001, 2);

        // Node 0: response timeout then a retry that is ACKed.
        exp_q.push_back({1'b0, 4'b0001});
        send_packet();
        repeat (RESP_TO - 1) @(posedge clk);
        #1;
        check("resp_to_still_waiting", dbg.state, ST_WAIT_RESP);
        @(posedge clk);
        #1;
        check("resp_to_regrant_state", dbg.state, ST_GRANT);
        check("resp_to_regrant", grant, 4'b0001);
        send_packet();
        send_response(3, DATA_ONES, PACKET_BITS);
        expect_eval("ack_after_to", 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        req = 4'b0110;
        wait_grant("rr_after_to", 4'b0010, 2);

        // Node 1 withdraws before its start bit: back to IDLE, ptr kept at 1.
        repeat (3) @(negedge clk);
        req = 4'b0100;
        @(posedge clk);
        #1;
        check("withdraw_grant", grant, 4'b0000);
        check("withdraw_busy", busy, 1'b0);
        @(negedge clk);
        req = 4'b0110;
        wait_grant("ptr_kept", 4'b0010, 1);

        // Reset in the middle of the response capture.
        send_packet();
        send_response(0, DATA_ONES, 31);
        @(posedge clk);
        #1;
        check("recv_before_rst", dbg.state, ST_RECV);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_recv_grant", grant, 4'b0000);
        check("rst_recv_busy", busy, 1'b0);
        check("rst_recv_pulses", {done, fail}, '0);
        check("rst_recv_capture", dbg.capture, ALL1);
        @(negedge clk);
        rst     = 1'b0;
        line_in = 1'b1;
        req     = 4'b1001;
        wait_grant("ptr_reset", 4'b0001, 1);

        // Final clean ACK after reset.
        exp_q.push_back({1'b0, 4'b0001});
        send_packet();
        send_response(1, DATA_ONES, PACKET_BITS);
        expect_eval("ack_final", 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        req = '0;
        repeat (4) @(posedge clk);
        #3;
        check("final_idle", busy, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("invariants", inv_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
